// File: rtl/tnet_tx_queue.sv
// rtl/tnet_tx_queue.sv - tnet transmit packet queue with 4-phase req/ack handshake
//
// Ports:
//   clk_i, rst_ni             block clock, asynchronous active-low reset
//   pkt_valid_i/pkt_ready_o   enqueue handshake (ready == !full)
//   pkt_op_i/pkt_sync_i/pkt_dst_i/pkt_dt_i, ID
//                             packet fields; ID is the own node ID (source field)
//   tx_req_o/tx_dt_o/tx_ack_i 4-phase handshake to the link controller (ack async)
//   err_clr_i/tx_err_o        sticky ack-timeout flag and its clear
//   fifo_cnt_o/sent_cnt_o     packets queued / packets acknowledged
module tnet_tx_queue #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT     = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   pkt_valid_i,
    output logic                   pkt_ready_o,
    input  logic [7:0]             pkt_op_i,
    input  logic                   pkt_sync_i,
    input  logic [8:0]             pkt_dst_i,
    input  logic [95:0]            pkt_dt_i,
    input  logic [7:0]             ID,
    output logic                   tx_req_o,
    output logic [127:0]           tx_dt_o,
    input  logic                   tx_ack_i,
    input  logic                   err_clr_i,
    output logic                   tx_err_o,
    output logic [$clog2(DEPTH):0] fifo_cnt_o,
    output logic [15:0]            sent_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT_NACK
    } state_e;

    // Queue storage and bookkeeping
    logic [127:0]           mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   avail_q, avail_d;
    logic                   push, pop;
    logic [127:0]           wr_word;

    // Handshake side
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_s;
    state_e                 state_q, state_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic                   req_q, req_d;
    logic [127:0]           dt_q, dt_d;
    logic                   err_q, err_d;
    logic [15:0]            sent_q, sent_d;
    logic                   load_dt, req_set, acked, abort;

    assign pkt_ready_o = (cnt_q != FULL_CNT);
    assign push        = pkt_valid_i & pkt_ready_o;
    assign wr_word     = {pkt_op_i, pkt_sync_i, 5'b00000, pkt_dst_i, 1'b0, ID, pkt_dt_i};
    assign ack_s       = ack_sync_q[SYNC_STAGES-1];
    assign pop         = acked | abort;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // Registered non-empty flag: adds the cycle between enqueue and the
        // head load, and is always settled by the time WAIT_nACK returns to IDLE.
        avail_d = (cnt_q != '0);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    always_comb begin
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], tx_ack_i};
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (avail_q) state_d = S_LOAD;
            S_LOAD:      state_d = S_REQ;
            S_REQ:       if (ack_s || (to_cnt_q == TO_LAST)) state_d = S_WAIT_NACK;
            S_WAIT_NACK: if (!ack_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // FSM outputs; ack is only looked at in REQ/WAIT_nACK, so a spurious
    // ack in IDLE or LOAD has no effect.
    always_comb begin
        load_dt = 1'b0;
        req_set = 1'b0;
        acked   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: load_dt = avail_q;
            S_LOAD: req_set = 1'b1;
            S_REQ: begin
                acked = ack_s;
                abort = !ack_s && (to_cnt_q == TO_LAST);
            end
            default: ;
        endcase
    end

    always_comb begin
        dt_d     = load_dt ? mem_q[rd_ptr_q] : dt_q;
        req_d    = req_q;
        to_cnt_d = to_cnt_q;
        sent_d   = sent_q;
        err_d    = err_q;
        if (req_set) begin
            req_d    = 1'b1;
            to_cnt_d = '0;
        end else if ((state_q == S_REQ) && !pop) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
        if (pop) begin
            req_d = 1'b0;
        end
        if (acked) begin
            sent_d = sent_q + 16'd1;
        end
        // An abort in the same cycle as a clear must leave the flag set.
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (abort) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            avail_q    <= 1'b0;
            ack_sync_q <= '0;
            state_q    <= S_IDLE;
            to_cnt_q   <= '0;
            req_q      <= 1'b0;
            dt_q       <= '0;
            err_q      <= 1'b0;
            sent_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            avail_q    <= avail_d;
            ack_sync_q <= ack_sync_d;
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            req_q      <= req_d;
            dt_q       <= dt_d;
            err_q      <= err_d;
            sent_q     <= sent_d;
        end
    end

    assign tx_req_o   = req_q;
    assign tx_dt_o    = dt_q;
    assign tx_err_o   = err_q;
    assign fifo_cnt_o = cnt_q;
    assign sent_cnt_o = sent_q;

endmodule

// File: tb/tb_tnet_tx_queue.sv
// tb/tb_tnet_tx_queue.sv - self-checking scoreboard bench for tnet_tx_queue
module tb_tnet_tx_queue;
    localparam int DEPTH       = 8;
    localparam int TIMEOUT     = 16;
    localparam int SYNC_STAGES = 2;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [7:0]    pkt_op;
    logic          pkt_sync;
    logic [8:0]    pkt_dst;
    logic [95:0]   pkt_dt;
    logic [7:0]    node_id;
    logic          tx_req;
    logic [127:0]  tx_dt;
    logic          tx_ack;
    logic          err_clr;
    logic          tx_err;
    logic [CW-1:0] fifo_cnt;
    logic [15:0]   sent_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_pushed = 0;
    int n_popped = 0;
    logic [127:0] exp_q [$];

    bit mon_en     = 1'b0;
    bit cnt_chk_en = 1'b0;
    bit req_prev   = 1'b0;
    bit ack_en     = 1'b0;
    bit ack_hold   = 1'b0;
    int ack_delay  = 6;
    int ack_wait   = 0;

    tnet_tx_queue #(
        .DEPTH      (DEPTH),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pkt_valid_i(pkt_valid),
        .pkt_ready_o(pkt_ready),
        .pkt_op_i   (pkt_op),
        .pkt_sync_i (pkt_sync),
        .pkt_dst_i  (pkt_dst),
        .pkt_dt_i   (pkt_dt),
        .ID         (node_id),
        .tx_req_o   (tx_req),
        .tx_dt_o    (tx_dt),
        .tx_ack_i   (tx_ack),
        .err_clr_i  (err_clr),
        .tx_err_o   (tx_err),
        .fifo_cnt_o (fifo_cnt),
        .sent_cnt_o (sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_pkt(input logic [7:0] op, input logic s,
                                            input logic [8:0] dst, input logic [7:0] id,
                                            input logic [95:0] dt);
        return {op, s, 5'b00000, dst, 1'b0, id, dt};
    endfunction

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic push_pkt(input logic [7:0] op, input logic s, input logic [8:0] dst,
                            input logic [95:0] dt);
        int w = 0;
        while (!pkt_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!pkt_ready) begin
            chk("push_timeout", 128'(pkt_ready), 128'(1));
            return;
        end
        pkt_valid = 1'b1;
        pkt_op    = op;
        pkt_sync  = s;
        pkt_dst   = dst;
        pkt_dt    = dt;
        @(posedge clk);
        exp_q.push_back(mk_pkt(op, s, dst, node_id, dt));
        n_pushed++;
        @(negedge clk);
        pkt_valid = 1'b0;
    endtask

    task automatic wait_req(input logic val, input int budget, input string tag);
        int w = 0;
        while (tx_req !== val && w < budget) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 128'(tx_req), 128'(val));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int w = 0;
        while ((fifo_cnt != 0 || tx_req || tx_ack) && w < budget) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 128'(fifo_cnt == 0 && !tx_req && !tx_ack), 128'(1));
        repeat (SYNC_STAGES + 3) @(negedge clk);
    endtask

    // Link controller model: raise ack ack_delay cycles after req, drop it once req falls.
    initial begin
        tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_req && !tx_ack) begin
                if (ack_en) begin
                    if (ack_wait >= ack_delay - 1) begin
                        tx_ack   = 1'b1;
                        ack_wait = 0;
                    end else begin
                        ack_wait++;
                    end
                end
            end else if (!tx_req) begin
                ack_wait = 0;
                if (tx_ack && !ack_hold) tx_ack = 1'b0;
            end
        end
    end

    // Scoreboard: each request rise presents the next queued packet; each fall is a pop.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (tx_req && !req_prev) begin
                    chk("sb_has_entry", 128'(exp_q.size() != 0), 128'(1));
                    if (exp_q.size() != 0) chk("pkt_data", tx_dt, exp_q.pop_front());
                end
                if (!tx_req && req_prev) begin
                    n_popped++;
                    if (cnt_chk_en) chk("fifo_cnt_at_pop", 128'(fifo_cnt), 128'(n_pushed - n_popped));
                end
            end
            req_prev = tx_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        pkt_valid = 1'b0;
        pkt_op    = '0;
        pkt_sync  = 1'b0;
        pkt_dst   = '0;
        pkt_dt    = '0;
        node_id   = 8'h03;
        err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req",   128'(tx_req),    128'(0));
        chk("rst_dt",    tx_dt,           128'(0));
        chk("rst_err",   128'(tx_err),    128'(0));
        chk("rst_sent",  128'(sent_cnt),  128'(0));
        chk("rst_fifo",  128'(fifo_cnt),  128'(0));
        chk("rst_ready", 128'(pkt_ready), 128'(1));
        rst_n      = 1'b1;
        mon_en     = 1'b1;
        cnt_chk_en = 1'b1;
        @(negedge clk);

        // Single packet with latency checks
        ack_en    = 1'b1;
        ack_delay = 6;
        pkt_valid = 1'b1;
        pkt_op    = 8'h11;
        pkt_sync  = 1'b0;
        pkt_dst   = 9'h005;
        pkt_dt    = 96'hAAAA_5555_0123_4567_89AB_CDEF;
        @(posedge clk);
        exp_q.push_back(mk_pkt(8'h11, 1'b0, 9'h005, 8'h03, 96'hAAAA_5555_0123_4567_89AB_CDEF));
        n_pushed++;
        @(negedge clk);
        pkt_valid = 1'b0;
        chk("lat_n0_req", 128'(tx_req),   128'(0));
        chk("lat_n0_cnt", 128'(fifo_cnt), 128'(1));
        @(negedge clk);
        chk("lat_n1_dt", tx_dt, 128'(0));
        @(negedge clk);
        chk("lat_n2_dt",  tx_dt, mk_pkt(8'h11, 1'b0, 9'h005, 8'h03, 96'hAAAA_5555_0123_4567_89AB_CDEF));
        chk("lat_n2_req", 128'(tx_req), 128'(0));
        @(negedge clk);
        chk("lat_n3_req", 128'(tx_req), 128'(1));
        chk("single_hdr", 128'(tx_dt[127:96]), 128'(32'h1100_0A03));
        wait_req(1'b0, 40, "single_req_drop");
        wait_idle(40, "single_idle");
        chk("single_sent", 128'(sent_cnt), 128'(1));
        chk("single_fifo", 128'(fifo_cnt), 128'(0));
        chk("single_err",  128'(tx_err),   128'(0));

        // Fill to DEPTH with ack held off, then a 9th push waits for space
        ack_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_pkt(8'h20 + 8'(i), 1'(i % 2), (i == 3) ? 9'h1FF : 9'(i * 37),
                     {$urandom, $urandom, $urandom});
        end
        chk("full_cnt",   128'(fifo_cnt),  128'(8));
        chk("full_ready", 128'(pkt_ready), 128'(0));
        chk("full_req",   128'(tx_req),    128'(1));
        repeat (3) begin
            @(negedge clk);
            chk("full_hold_ready", 128'(pkt_ready), 128'(0));
        end
        ack_en    = 1'b1;
        ack_delay = 2;
        push_pkt(8'h29, 1'b1, 9'h1FF, 96'h0123_4567_89AB_CDEF_FEDC_BA98);
        chk("refill_cnt", 128'(fifo_cnt), 128'(8));

        // Streaming with random gaps: pushes coincide with pops, pointers wrap
        ack_delay = 1;
        for (int i = 0; i < 16; i++) begin
            push_pkt(8'h40 + 8'(i), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
                     {$urandom, $urandom, $urandom});
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(800, "stream_idle");
        chk("stream_sent", 128'(sent_cnt), 128'(26));
        chk("stream_err",  128'(tx_err),   128'(0));

        // Ack timeout, error clear, and clear coincident with an abort
        ack_en = 1'b0;
        push_pkt(8'h61, 1'b0, 9'h011, 96'h1);
        push_pkt(8'h62, 1'b1, 9'h022, 96'h2);
        wait_req(1'b1, 40, "to_req_rise");
        n = 0;
        while (tx_req && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("to_req_cycles", 128'(n),        128'(TIMEOUT));
        chk("to_err",        128'(tx_err),   128'(1));
        chk("to_sent",       128'(sent_cnt), 128'(26));
        chk("to_fifo",       128'(fifo_cnt), 128'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", 128'(tx_err), 128'(0));
        wait_req(1'b1, 40, "to2_req_rise");
        repeat (TIMEOUT - 1) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_set_wins", 128'(tx_err),   128'(1));
        chk("to2_req",      128'(tx_req),   128'(0));
        chk("to2_fifo",     128'(fifo_cnt), 128'(0));
        chk("to2_sent",     128'(sent_cnt), 128'(26));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr2", 128'(tx_err), 128'(0));

        // Ack arriving just after an abort: held in WAIT_nACK, no extra pop
        ack_en    = 1'b1;
        ack_delay = TIMEOUT - 1;
        ack_hold  = 1'b1;
        push_pkt(8'h71, 1'b0, 9'h033, 96'h3);
        push_pkt(8'h72, 1'b0, 9'h044, 96'h4);
        wait_req(1'b1, 40, "late_req_rise");
        wait_req(1'b0, 40, "late_req_fall");
        chk("late_err",  128'(tx_err),   128'(1));
        chk("late_sent", 128'(sent_cnt), 128'(26));
        repeat (8) begin
            @(negedge clk);
            chk("late_hold_req", 128'(tx_req),   128'(0));
            chk("late_hold_cnt", 128'(fifo_cnt), 128'(1));
        end
        ack_delay = 3;
        ack_hold  = 1'b0;
        wait_idle(100, "late_idle");
        chk("late_sent_after", 128'(sent_cnt), 128'(27));
        chk("late_err_sticky", 128'(tx_err),   128'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Reset while a request is outstanding with 3 packets queued
        ack_en = 1'b0;
        push_pkt(8'h81, 1'b0, 9'h055, 96'h5);
        push_pkt(8'h82, 1'b0, 9'h066, 96'h6);
        push_pkt(8'h83, 1'b0, 9'h077, 96'h7);
        wait_req(1'b1, 40, "pre_rst_req");
        chk("pre_rst_fifo", 128'(fifo_cnt), 128'(3));
        cnt_chk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",   128'(tx_req),    128'(0));
        chk("mid_rst_fifo",  128'(fifo_cnt),  128'(0));
        chk("mid_rst_ready", 128'(pkt_ready), 128'(1));
        chk("mid_rst_dt",    tx_dt,           128'(0));
        chk("mid_rst_sent",  128'(sent_cnt),  128'(0));
        chk("mid_rst_err",   128'(tx_err),    128'(0));
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        n_pushed = 0;
        n_popped = 0;
        rst_n    = 1'b1;
        @(negedge clk);
        cnt_chk_en = 1'b1;
        ack_en     = 1'b1;
        ack_delay  = 4;
        node_id    = 8'h7E;
        push_pkt(8'h5A, 1'b1, 9'h0C3, 96'hDEAD_BEEF_0000_1111_2222_3333);
        node_id = 8'h55;
        wait_idle(60, "post_rst_idle");
        chk("post_rst_sent", 128'(sent_cnt),     128'(1));
        chk("post_rst_fifo", 128'(fifo_cnt),     128'(0));
        chk("sb_drained",    128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tnet_tx_queue.md
Name: tnet_tx_queue

Overview:
- Transmit-side packet source for the tnet link controller: queues outgoing commands, assembles 128-bit tnet packets and hands them one at a time over the 4-phase tx_req/tx_ack handshake.
- Sits directly upstream of the link controller's transmit port; the controller drives tx_ack from another clock domain, so ack is synchronised here.
- Provides ack timeout, sticky error and a sent-packet counter for status registers.

Parameters:
- DEPTH, 8, queue depth in packets; power of 2, ≥2.
- TIMEOUT, 1024, cycles tx_req_o may stay high without ack before abort; ≥4.
- SYNC_STAGES, 2, flops in tx_ack_i synchroniser; ≥2.

Ports:
- clk_i  in  1  block clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- pkt_valid_i  in  1  enqueue request.
- pkt_ready_o  out  1  queue can accept; equals !full.
- pkt_op_i  in  8  opcode.
- pkt_sync_i  in  1  sync-propagate flag.
- pkt_dst_i  in  9  destination; 0x1FF = broadcast.
- pkt_dt_i  in  96  payload (3 words).
- ID  in  8  own node ID, used as source field.
- tx_req_o  out  1  handshake request to link controller.
- tx_dt_o  out  128  packet to link controller.
- tx_ack_i  in  1  handshake ack, asynchronous to clk_i.
- err_clr_i  in  1  clears tx_err_o.
- tx_err_o  out  1  sticky ack-timeout flag.
- fifo_cnt_o  out  $clog2(DEPTH)+1  packets queued.
- sent_cnt_o  out  16  acked packets, wraps 0xFFFF→0.

Behaviour:
- Packet layout: [127:120] op; [119] sync; [118:114] 0; [113:105] dst; [104:96] {1'b0,ID}; [95:0] pkt_dt_i. ID is sampled at enqueue.
- Push when pkt_valid_i & pkt_ready_o. Pop on ack or abort.
- Simultaneous push and pop: count unchanged, including when full (pkt_ready_o stays 0 while full; no push when full).
- Empty: no pop is possible, because the FSM only loads from a non-empty queue.
- Pointers wrap modulo DEPTH.
- ack_s is tx_ack_i after SYNC_STAGES flops, reset 0.
- FSM IDLE: if queue not empty, register head into tx_dt_o, go to LOAD.
- FSM LOAD: set tx_req_o=1, clear timeout counter, go to REQ.
  - tx_dt_o is therefore stable at least 1 cycle before req rises, and stays stable until WAIT_nACK exits.
- FSM REQ:
  - If ack_s=1: tx_req_o=0, pop, increment sent_cnt_o, go to WAIT_nACK.
  - Else if the counter reaches TIMEOUT-1: abort. tx_req_o=0, pop (packet dropped), set tx_err_o, go to WAIT_nACK.
  - Otherwise increment the counter.
- FSM WAIT_nACK: stay until ack_s=0, then go to IDLE. This also absorbs a late ack arriving after an abort.
- Latency: push at edge N into an empty queue gives tx_dt_o valid after edge N+2 and tx_req_o high after edge N+3.
- Minimum cycles per packet: 4 + handshake round trip.
- tx_err_o: set by abort, cleared by err_clr_i. If both happen in the same cycle, set wins.
- Reset values: tx_req_o=0, tx_dt_o=0, tx_err_o=0, sent_cnt_o=0, fifo_cnt_o=0, pkt_ready_o=1, FSM=IDLE, synchroniser=0.
- Reset mid-operation: queue contents discarded and req dropped immediately (async). The downstream side returns to idle on seeing req low.
- tx_ack_i rising while in IDLE or LOAD (spurious): ignored. The FSM reacts only in REQ and WAIT_nACK.

Test Plan:
- Single packet: push op=0x11, sync=0, dst=0x005, ID=0x03, dt=0xA..; ack model 6 cycles after req → tx_dt_o=0x1100_0A03_…, req high after edge N+3, then drops; sent_cnt_o=1, fifo_cnt_o=0.
- Fill: push 9 packets back-to-back with DEPTH=8 and ack held off → pkt_ready_o=0 after 8th accepted, fifo_cnt_o=8, 9th held. Release ack → packets emitted in push order, 9th then accepted.
- Push/pop same cycle while full → fifo_cnt_o stays 8, no data lost, order preserved.
- Timeout: never ack, TIMEOUT=16 → req falls after 16 cycles in REQ, tx_err_o=1, packet dropped, next packet proceeds only after ack_s=0. Pulse err_clr_i → tx_err_o=0. err_clr_i coincident with second abort → tx_err_o=1.
- Late ack after abort → held in WAIT_nACK until ack drops; no double pop, sent_cnt_o unchanged.
- Assert rst_ni low during REQ with 3 packets queued → tx_req_o=0 immediately, fifo_cnt_o=0; after release, a new push transmits normally.
